// File: rtl/mips_pkg.sv
// Shared types and instruction field positions for the MIPS pipeline register bank.
package mips_pkg;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic regdst;
    logic valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam int REG_W  = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

endpackage

// File: rtl/flopenrc.sv
// Flop with enable and synchronous clear; clear only acts on enabled cycles.
module flopenrc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Stage-register bank for the 5-stage MIPS core: PC, IR, E/M/W control and
// register-index fields, plus cycle/retire/stall performance counters.
module pipe_ctrl_regs
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pcnextF,
  input  logic [31:0]      instrF,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             pcsrcD,
  input  logic             regwriteD,
  input  logic             memtoregD,
  input  logic             memwriteD,
  input  logic             regdstD,
  output logic [31:0]      pcF,
  output logic [31:0]      instrD,
  output logic [31:0]      pcplus4D,
  output logic [REG_W-1:0] rsD,
  output logic [REG_W-1:0] rtD,
  output logic [REG_W-1:0] rsE,
  output logic [REG_W-1:0] rtE,
  output logic [REG_W-1:0] writeregE,
  output logic             regwriteE,
  output logic             memtoregE,
  output logic             memwriteE,
  output logic [REG_W-1:0] writeregM,
  output logic [REG_W-1:0] writeregW,
  output logic             regwriteM,
  output logic             memtoregM,
  output logic             memwriteM,
  output logic             regwriteW,
  output logic             memtoregW,
  output logic             retireW,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      ret_cnt,
  output logic [31:0]      stl_cnt
);

  localparam int D_W = 32 + 32 + 1;
  localparam int E_W = $bits(ctrl_t) + 3 * REG_W;

  logic             validD;
  logic [REG_W-1:0] rdD;
  logic [D_W-1:0]   qD;
  ctrl_t            ctrlD;
  ctrl_t            ctrlE;
  logic [REG_W-1:0] rdE;
  logic [E_W-1:0]   qE;
  logic             validM;
  logic             validW;
  logic [31:0]      cycCnt;
  logic [31:0]      retCnt;
  logic [31:0]      stlCnt;

  // F stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcF <= RESET_PC;
    end else if (!stallF) begin
      pcF <= pcnextF;
    end
  end

  // D stage: stall holds, a taken branch loads a bubble
  flopenrc #(.DATA_W(D_W)) uStageD (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stallD),
    .clr   (pcsrcD),
    .d     ({instrF, pcF + 32'd4, 1'b1}),
    .q     (qD)
  );

  assign {instrD, pcplus4D, validD} = qD;
  assign rsD = instrD[RS_MSB:RS_LSB];
  assign rtD = instrD[RT_MSB:RT_LSB];
  assign rdD = instrD[RD_MSB:RD_LSB];
  assign ctrlD = '{regwrite: regwriteD, memtoreg: memtoregD, memwrite: memwriteD,
                   regdst: regdstD, valid: validD};

  // E stage
  flopenrc #(.DATA_W(E_W)) uStageE (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (flushE),
    .d     ({ctrlD, rsD, rtD, rdD}),
    .q     (qE)
  );

  assign {ctrlE, rsE, rtE, rdE} = qE;
  assign regwriteE = ctrlE.regwrite;
  assign memtoregE = ctrlE.memtoreg;
  assign memwriteE = ctrlE.memwrite;
  assign writeregE = ctrlE.regdst ? rdE : rtE;

  // M and W stages always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeregM <= '0;
      regwriteM <= 1'b0;
      memtoregM <= 1'b0;
      memwriteM <= 1'b0;
      validM    <= 1'b0;
      writeregW <= '0;
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      validW    <= 1'b0;
    end else begin
      writeregM <= writeregE;
      regwriteM <= ctrlE.regwrite;
      memtoregM <= ctrlE.memtoreg;
      memwriteM <= ctrlE.memwrite;
      validM    <= ctrlE.valid;
      writeregW <= writeregM;
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
      validW    <= validM;
    end
  end

  assign retireW = validW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycCnt <= '0;
      retCnt <= '0;
      stlCnt <= '0;
    end else begin
      cycCnt <= cycCnt + 32'd1;
      if (retireW) retCnt <= retCnt + 32'd1;
      if (stallD)  stlCnt <= stlCnt + 32'd1;
    end
  end

  assign cyc_cnt = cycCnt;
  assign ret_cnt = retCnt;
  assign stl_cnt = stlCnt;

endmodule
